vending_machine_multi: RTL and testbench
========================================

Name: vending_machine_multi

Overview:
Parametrised successor to the two-can coin vending controller. Supports N products with individual prices, a bounded credit accumulator counted in nickels, cancel/refund, and serial change return. It sits between the registered coin acceptor inputs and the dispenser/coin-return actuators. It replaces the fixed S0..S15 coin collector with a credit counter plus a four-state vend FSM.

Parameters:
NUM_CANS, 3, number of products; selectable codes are 1..NUM_CANS, and 0 means no choice.
BASE_PRICE, 3, price of can 1 in nickels.
PRICE_STEP, 1, price increment per can index: price(k) = BASE_PRICE + (k-1)*PRICE_STEP.
MAX_CREDIT, 20, credit ceiling in nickels (100c).
CREDIT_W, 5, credit counter width; must satisfy MAX_CREDIT < 2**CREDIT_W.
CAN_W (localparam), clog2(NUM_CANS+1), width of the can code.

Ports:
clk  in  1  single clock, rising edge.
async_reset_n  in  1  asynchronous, active-low reset.
coin_in  in  2  coin code: 00 none, 01 nickel (1), 10 dime (2), 11 quarter (5).
choose  in  1  request to enter selection.
can_choice  in  CAN_W  selected can code; 0 means none.
cancel  in  1  abort and refund all credit.
can_out  out  CAN_W  dispensed can code; nonzero only during VEND.
vend_valid  out  1  one-cycle dispense strobe.
change_out  out  1  one nickel returned per high cycle.
eject_out  out  1  one-cycle pulse: the incoming coin was rejected and returned.
short_credit  out  1  one-cycle pulse: the selected can costs more than the current credit.
credit  out  CREDIT_W  current credit in nickels, for the display.

Behaviour:
- Reset: asynchronous assert while async_reset_n=0; synchronous release. On reset, state=COLLECT, credit=0, coin register=00, and all outputs are 0. Reset during CHANGE forfeits any remaining credit.
- Coin path: coin_in is registered into coin_q at edge N. coin_q is evaluated at edge N+1, which is when credit and eject_out update.
- Coin handling in COLLECT: if credit + value(coin_q) <= MAX_CREDIT, credit adds value(coin_q). Otherwise credit is unchanged and eject_out=1 for one cycle.
- Coin handling in any other state: every nonzero coin_q is ejected (eject_out=1) and credit is unchanged.
- State COLLECT:
  - cancel=1 and credit>0 -> CHANGE. cancel has priority over choose.
  - Otherwise, choose=1 and the post-add credit is >0 -> CHOOSE. A coin and choose arriving in the same cycle are both honoured.
  - choose with zero credit is ignored.
- State CHOOSE:
  - cancel=1 -> CHANGE.
  - can_choice=0 -> stay in CHOOSE.
  - can_choice > NUM_CANS -> stay in CHOOSE, eject_out=0, short_credit=0 (the code is ignored).
  - Valid code with credit >= price -> VEND. credit -= price, latched can code = can_choice.
  - Valid code with credit < price -> COLLECT, credit kept, short_credit=1 for one cycle.
- State VEND (exactly one cycle):
  - can_out = latched code, vend_valid=1.
  - Next state: CHANGE if the remaining credit >0, else COLLECT.
- State CHANGE:
  - Each cycle: change_out=1 and credit -= 1.
  - When the decremented credit reaches 0 -> COLLECT. A credit of c yields exactly c consecutive change_out cycles.
  - cancel and choose are ignored in CHANGE.
- Output timing: outputs are registered Moore outputs. can_out, vend_valid and change_out reflect the current state. can_out=0 outside VEND.
- Arithmetic: the add uses CREDIT_W+1 bits for the overflow compare. The subtract never underflows, because the FSM guards it.

Decomposition:
- Package vm_multi_pkg holds:
  - the coin code constants (COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER);
  - function coin_value(code) returning the value in nickels;
  - the state encoding COLLECT, CHOOSE, VEND, CHANGE;
  - function can_price(k, BASE_PRICE, PRICE_STEP).
- Sub-module vm_coin_credit contains the coin_q register, the value decode, the overflow check and the credit counter with add, subtract-price, decrement and hold controls.
- The top level contains the FSM and output registers.

Test Plan:
1. Nickel then dime (credit=3), then choose, then can_choice=1 -> one VEND cycle with can_out=1 and vend_valid=1; credit=0, no change_out, return to COLLECT.
2. Quarter (credit=5), choose, can_choice=2 (price 4) -> VEND with can_out=2, then exactly 1 change_out cycle, credit=0.
3. Dime (credit=2), choose, can_choice=3 (price 5) -> short_credit pulse, back to COLLECT with credit=2; then cancel -> exactly 2 change_out cycles, credit=0.
4. Four quarters (credit=20), then a fifth quarter -> eject_out pulse, credit stays 20; then a nickel -> eject_out, credit 20.
5. In CHOOSE, drive coin_in=10 -> eject_out pulse, credit unchanged. Then can_choice=3'b111 (out of range, NUM_CANS=3) -> stays in CHOOSE with no pulses.
6. Credit=10, vend can 1 (price 3), and assert async_reset_n=0 during the 3rd change_out cycle -> all outputs and credit are 0 immediately, and the state is COLLECT after release.

Source files
------------

// File: rtl/vm_multi_pkg.sv
// Shared types and helpers for the multi-product vending controller:
// coin codes, FSM/credit-op encodings, coin value and can price functions.
package vm_multi_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHOOSE  = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CR_HOLD = 2'd0,
        CR_ADD  = 2'd1,
        CR_SUB  = 2'd2,
        CR_DEC  = 2'd3
    } credit_op_e;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_NICKEL:  return 3'd1;
            COIN_DIME:    return 3'd2;
            COIN_QUARTER: return 3'd5;
            default:      return 3'd0;
        endcase
    endfunction

    // Only meaningful for k >= 1; callers gate k == 0 separately.
    function automatic int unsigned can_price(input int unsigned k,
                                              input int unsigned base_price,
                                              input int unsigned price_step);
        return base_price + (k - 1) * price_step;
    endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Coin acceptor / selection / actuator signals of the vending controller.
// The master drives the customer-side inputs, the slave is the controller.
interface vending_machine_multi_if #(
    parameter int unsigned NUM_CANS = 3,
    parameter int unsigned CREDIT_W = 5
);
    localparam int unsigned CAN_W = $clog2(NUM_CANS + 1);

    logic [1:0]          coin_in;
    logic                choose;
    logic [CAN_W-1:0]    can_choice;
    logic                cancel;
    logic [CAN_W-1:0]    can_out;
    logic                vend_valid;
    logic                change_out;
    logic                eject_out;
    logic                short_credit;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin_in, choose, can_choice, cancel,
        input  can_out, vend_valid, change_out, eject_out, short_credit, credit
    );

    modport slave (
        input  coin_in, choose, can_choice, cancel,
        output can_out, vend_valid, change_out, eject_out, short_credit, credit
    );

endinterface

// File: rtl/vm_coin_credit.sv
// Coin register and bounded credit counter. The FSM picks the counter op;
// this block decides whether the registered coin is accepted or rejected.
module vm_coin_credit
    import vm_multi_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 20,
    parameter int unsigned CREDIT_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin_in,
    input  credit_op_e          op,
    input  logic [CREDIT_W-1:0] price,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] credit_post_add,
    output logic                coin_reject
);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    logic [1:0]          coin_q;
    logic [1:0]          coin_d;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic [SUM_W-1:0]    sum;
    logic                fits;

    // Extra bit keeps the ceiling compare honest when the add wraps CREDIT_W.
    assign sum  = {1'b0, credit_q} + SUM_W'(coin_value(coin_q));
    assign fits = (sum <= SUM_W'(MAX_CREDIT));

    always_comb begin
        coin_d          = coin_in;
        credit_post_add = fits ? sum[CREDIT_W-1:0] : credit_q;
        coin_reject     = (coin_q != COIN_NONE) && !((op == CR_ADD) && fits);
        credit_d        = credit_q;
        case (op)
            CR_ADD:  credit_d = credit_post_add;
            CR_SUB:  credit_d = credit_q - price;
            CR_DEC:  credit_d = credit_q - CREDIT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_q   <= COIN_NONE;
            credit_q <= '0;
        end else begin
            coin_q   <= coin_d;
            credit_q <= credit_d;
        end
    end

    assign credit = credit_q;

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: credit counter plus a four-state vend FSM
// with registered Moore outputs and serial nickel change return.
module vending_machine_multi
    import vm_multi_pkg::*;
#(
    parameter int unsigned NUM_CANS   = 3,
    parameter int unsigned BASE_PRICE = 3,
    parameter int unsigned PRICE_STEP = 1,
    parameter int unsigned MAX_CREDIT = 20,
    parameter int unsigned CREDIT_W   = 5
) (
    input  logic                    clk,
    input  logic                    async_reset_n,
    vending_machine_multi_if.slave  vm
);
    localparam int unsigned CAN_W   = $clog2(NUM_CANS + 1);
    localparam int unsigned PRICE_W = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CAN_W-1:0]    can_out_q, can_out_d;
    logic                vend_valid_q, vend_valid_d;
    logic                change_out_q, change_out_d;
    logic                eject_q, eject_d;
    logic                short_q, short_d;

    credit_op_e          cr_op;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_post_add;
    logic                coin_reject;
    logic [PRICE_W-1:0]  price;
    logic                code_valid;

    assign price      = PRICE_W'(can_price(32'(vm.can_choice), BASE_PRICE, PRICE_STEP));
    assign code_valid = (vm.can_choice != '0) && (32'(vm.can_choice) <= NUM_CANS);

    vm_coin_credit #(
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W)
    ) u_coin_credit (
        .clk             (clk),
        .rst_n           (async_reset_n),
        .coin_in         (vm.coin_in),
        .op              (cr_op),
        .price           (price[CREDIT_W-1:0]),
        .credit          (credit),
        .credit_post_add (credit_post_add),
        .coin_reject     (coin_reject)
    );

    always_comb begin
        state_d   = state_q;
        cr_op     = CR_HOLD;
        can_out_d = '0;
        short_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                cr_op = CR_ADD;
                if (vm.cancel && (credit != '0)) begin
                    state_d = CHANGE;
                end else if (vm.choose && (credit_post_add != '0)) begin
                    state_d = CHOOSE;
                end
            end
            CHOOSE: begin
                if (vm.cancel) begin
                    state_d = CHANGE;
                end else if (code_valid) begin
                    if ({1'b0, credit} >= price) begin
                        cr_op     = CR_SUB;
                        can_out_d = vm.can_choice;
                        state_d   = VEND;
                    end else begin
                        short_d = 1'b1;
                        state_d = COLLECT;
                    end
                end
            end
            VEND: state_d = (credit != '0) ? CHANGE : COLLECT;
            CHANGE: begin
                cr_op = CR_DEC;
                if (credit <= CREDIT_W'(1)) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        // Outputs are registered against the next state so they line up with it.
        vend_valid_d = (state_d == VEND);
        change_out_d = (state_d == CHANGE);
        eject_d      = coin_reject;
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q      <= COLLECT;
            can_out_q    <= '0;
            vend_valid_q <= 1'b0;
            change_out_q <= 1'b0;
            eject_q      <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            can_out_q    <= can_out_d;
            vend_valid_q <= vend_valid_d;
            change_out_q <= change_out_d;
            eject_q      <= eject_d;
            short_q      <= short_d;
        end
    end

    assign vm.can_out      = can_out_q;
    assign vm.vend_valid   = vend_valid_q;
    assign vm.change_out   = change_out_q;
    assign vm.eject_out    = eject_q;
    assign vm.short_credit = short_q;
    assign vm.credit       = credit;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: per-cycle vector table with an
// expectation queue, plus hand-written async-reset sequences.
module tb_vending_machine_multi;

    // Five products gives a 3-bit code, so code 7 exists and is out of range.
    // Prices of cans 1..3 are the same as with three products.
    localparam int unsigned NUM_CANS = 5;
    localparam int unsigned CREDIT_W = 5;

    typedef struct {
        logic [1:0] coin;
        logic       choose;
        logic [2:0] choice;
        logic       cancel;
        logic [2:0] can;
        logic       vv;
        logic       ch;
        logic       ej;
        logic       sc;
        logic [4:0] cr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    vec_t tbl[$];
    vec_t exp_q[$];

    vending_machine_multi_if #(.NUM_CANS(NUM_CANS), .CREDIT_W(CREDIT_W)) vif ();

    vending_machine_multi #(
        .NUM_CANS   (NUM_CANS),
        .BASE_PRICE (3),
        .PRICE_STEP (1),
        .MAX_CREDIT (20),
        .CREDIT_W   (CREDIT_W)
    ) dut (
        .clk           (clk),
        .async_reset_n (rst_n),
        .vm            (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] coin, input logic choose,
                                input logic [2:0] choice, input logic cancel,
                                input logic [2:0] can, input logic vv, input logic ch,
                                input logic ej, input logic sc, input logic [4:0] cr);
        vec_t v;
        v.coin = coin; v.choose = choose; v.choice = choice; v.cancel = cancel;
        v.can = can; v.vv = vv; v.ch = ch; v.ej = ej; v.sc = sc; v.cr = cr;
        return v;
    endfunction

    task automatic check(input string name);
        vec_t e;
        e = exp_q.pop_front();
        tests++;
        if ({vif.can_out, vif.vend_valid, vif.change_out, vif.eject_out,
             vif.short_credit, vif.credit} !==
            {e.can, e.vv, e.ch, e.ej, e.sc, e.cr}) begin
            fails++;
            $display("FAIL %s: got can=%0d vv=%0b ch=%0b ej=%0b sc=%0b cr=%0d, expected can=%0d vv=%0b ch=%0b ej=%0b sc=%0b cr=%0d",
                     name, vif.can_out, vif.vend_valid, vif.change_out, vif.eject_out,
                     vif.short_credit, vif.credit, e.can, e.vv, e.ch, e.ej, e.sc, e.cr);
        end
    endtask

    task automatic drive(input vec_t v);
        vif.coin_in    = v.coin;
        vif.choose     = v.choose;
        vif.can_choice = v.choice;
        vif.cancel     = v.cancel;
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic expect_zero_now(input string name);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check(name);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Nickel + dime, exact-price vend of can 1, no change
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Quarter, can 2 (price 4), one nickel change
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 2, 0, 2, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Dime, can 3 too expensive, then cancel refunds two nickels
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fill to the ceiling, fifth quarter and a nickel are ejected
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 15));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 20));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 20));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 20));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 20));
        // CHOOSE: coin ejected, out-of-range code ignored, then vend can 1
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 20));
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 20));
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0, 1, 0, 20));
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 20));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 17));
        // choose in VEND and cancel/choose in CHANGE are ignored
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 17));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 16));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 15));

        repeat (2) @(posedge clk);
        #1;
        expect_zero_now("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of change return clears everything at once
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        expect_zero_now("reset_in_change");
        @(negedge clk);
        rst_n = 1'b1;

        apply(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "r6_q1");
        apply(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 5), "r6_q2");
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 10), "r6_choose");
        apply(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 7), "r6_vend");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7), "r6_chg1");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 6), "r6_chg2");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5), "r6_chg3");
        #3;
        rst_n = 1'b0;
        #1;
        expect_zero_now("r6_reset_now");
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "r6_idle");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "r6_nickel");
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "r6_collect_choose");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1), "r6_short");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
